// File: rtl/sfr_bus_master_if.sv
// sfr_bus_master_if: host command/response handshake plus SFR initiator/responder bus
interface sfr_bus_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W/8-1:0] cmd_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              m_wr_en;
    logic              m_rd_en;
    logic [ADDR_W-1:0] m_waddr;
    logic [ADDR_W-1:0] m_raddr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W/8-1:0] m_wstrobe;
    logic              s_wready;
    logic              s_rvalid;
    logic [DATA_W-1:0] s_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               s_wready, s_rvalid, s_rdata,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error,
               m_wr_en, m_rd_en, m_waddr, m_raddr, m_wdata, m_wstrobe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               s_wready, s_rvalid, s_rdata,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error,
               m_wr_en, m_rd_en, m_waddr, m_raddr, m_wdata, m_wstrobe
    );
endinterface

// File: rtl/sfr_bus_master.sv
// sfr_bus_master: turns host register commands into SFR pulses with bounded wait and error responses
module sfr_bus_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    sfr_bus_master_if.master bus,
    output logic [7:0]       err_cnt
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_d;
    logic                op_write, op_write_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                rsp_valid_d, rsp_write_d, rsp_error_d;
    logic [DATA_W-1:0]   rsp_rdata_d, wdata_d;
    logic                wr_en_d, rd_en_d;
    logic [ADDR_W-1:0]   waddr_d, raddr_d;
    logic [DATA_W/8-1:0] wstrobe_d;
    logic [7:0]          err_cnt_d;
    logic                ack;

    // Only the acknowledge matching the outstanding operation counts
    assign ack = op_write ? bus.s_wready : bus.s_rvalid;

    always_comb begin
        state_d     = state;
        op_write_d  = op_write;
        cnt_d       = cnt;
        rsp_valid_d = bus.rsp_valid;
        rsp_write_d = bus.rsp_write;
        rsp_error_d = bus.rsp_error;
        rsp_rdata_d = bus.rsp_rdata;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        waddr_d     = bus.m_waddr;
        raddr_d     = bus.m_raddr;
        wdata_d     = bus.m_wdata;
        wstrobe_d   = bus.m_wstrobe;
        case (state)
            IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
                op_write_d  = bus.cmd_write;
                rsp_write_d = bus.cmd_write;
                rsp_rdata_d = '0;
                if (bus.cmd_addr[1:0] != 2'b00) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                end else begin
                    state_d = ISSUE;
                    wr_en_d = bus.cmd_write;
                    rd_en_d = !bus.cmd_write;
                    if (bus.cmd_write) begin
                        waddr_d   = bus.cmd_addr;
                        wdata_d   = bus.cmd_wdata;
                        wstrobe_d = bus.cmd_wstrb;
                    end else begin
                        raddr_d = bus.cmd_addr;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (ack) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b0;
                rsp_rdata_d = op_write ? '0 : bus.s_rdata;
            end else if (cnt == CNT_MAX) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b1;
                rsp_rdata_d = '0;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
            RESP: if (bus.rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        err_cnt_d = (state != RESP && state_d == RESP && rsp_error_d && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            op_write      <= 1'b0;
            cnt           <= '0;
            err_cnt       <= '0;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_write <= 1'b0;
            bus.rsp_error <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.m_wr_en   <= 1'b0;
            bus.m_rd_en   <= 1'b0;
            bus.m_waddr   <= '0;
            bus.m_raddr   <= '0;
            bus.m_wdata   <= '0;
            bus.m_wstrobe <= '0;
        end else begin
            state         <= state_d;
            op_write      <= op_write_d;
            cnt           <= cnt_d;
            err_cnt       <= err_cnt_d;
            bus.cmd_ready <= (state_d == IDLE);
            bus.rsp_valid <= rsp_valid_d;
            bus.rsp_write <= rsp_write_d;
            bus.rsp_error <= rsp_error_d;
            bus.rsp_rdata <= rsp_rdata_d;
            bus.m_wr_en   <= wr_en_d;
            bus.m_rd_en   <= rd_en_d;
            bus.m_waddr   <= waddr_d;
            bus.m_raddr   <= raddr_d;
            bus.m_wdata   <= wdata_d;
            bus.m_wstrobe <= wstrobe_d;
        end
    end
endmodule

// File: tb/tb_sfr_bus_master.sv
// tb_sfr_bus_master: randomized scoreboard bench with a modelled SFR responder
module tb_sfr_bus_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] err_cnt;
    logic       rr_hold = 1'b0;

    sfr_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sfr_bus_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic write; logic [DW-1:0] rdata; logic error; int at; } rsp_t;
    typedef struct { logic write; logic [AW-1:0] addr; logic [DW-1:0] data; logic [DW/8-1:0] strb; int at; } op_t;
    typedef struct { int k; logic [DW-1:0] rdata; int len; } cfg_t;

    rsp_t rsp_q[$];
    op_t  op_q[$];
    cfg_t cfg_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic outstanding = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: a command completes OK iff aligned and the responder acks within T wait cycles
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW/8-1:0] s, input int k, input logic [DW-1:0] rd, input int len);
        rsp_t r;
        op_t  o;
        cfg_t c;
        int   n;
        int   e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_wstrb = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_ready && n < 500);
        if (!bus.cmd_ready) begin
            flag("cmd_accept_timeout");
            bus.cmd_valid = 1'b0;
            return;
        end
        e = cyc + 1;
        r.write = w;
        if (a[1:0] != 2'b00) begin
            r.rdata = '0;
            r.error = 1'b1;
            r.at    = e;
        end else begin
            o.write = w; o.addr = a; o.data = d; o.strb = s; o.at = e;
            op_q.push_back(o);
            c.k = k; c.rdata = rd; c.len = len;
            cfg_q.push_back(c);
            r.error = (k >= T);
            r.rdata = (k < T && !w) ? rd : '0;
            r.at    = (k < T) ? e + 2 + k : e + 1 + T;
        end
        rsp_q.push_back(r);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_wstrb = 4'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || outstanding) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) flag("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rand_cmd(input logic aligned_only);
        logic          w;
        logic [AW-1:0] a;
        int            r, k;
        w = 1'($urandom_range(0, 1));
        a = $urandom;
        a[1:0] = (aligned_only || $urandom_range(0, 7) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
        r = $urandom_range(0, 9);
        k = (r < 6) ? $urandom_range(0, 3) : (r < 8) ? $urandom_range(4, T - 1) : $urandom_range(T, T + 3);
        send(w, a, $urandom, 4'($urandom), k, $urandom, $urandom_range(1, 3));
    endtask

    // Responder: acks k cycles after seeing an enable, plus stray acks wherever the DUT must ignore them
    initial begin
        int   cd, hold, len;
        logic rw, busy;
        logic [DW-1:0] rd;
        cfg_t c;
        cd = -1; hold = 0; len = 1; rw = 1'b0; busy = 1'b0; rd = '0;
        bus.s_wready = 1'b0;
        bus.s_rvalid = 1'b0;
        bus.s_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cd = -1; hold = 0; busy = 1'b0;
                bus.s_wready = 1'b0;
                bus.s_rvalid = 1'b0;
                continue;
            end
            if (bus.rsp_valid && bus.rsp_ready) busy = 1'b0;
            if (hold > 0) begin
                hold--;
                if (hold == 0) begin
                    bus.s_wready = 1'b0;
                    bus.s_rvalid = 1'b0;
                    bus.s_rdata  = $urandom;
                end
            end
            if (cd == 0) begin
                if (rw) bus.s_wready = 1'b1;
                else begin
                    bus.s_rvalid = 1'b1;
                    bus.s_rdata  = rd;
                end
                hold = len;
                cd = -1;
            end else if (cd > 0) cd--;
            if ((bus.m_wr_en || bus.m_rd_en) && cfg_q.size() != 0) begin
                c = cfg_q.pop_front();
                rw = bus.m_wr_en;
                rd = c.rdata;
                len = c.len;
                cd = (c.k < T) ? c.k : -1;
                busy = 1'b1;
            end
            if (hold == 0) begin
                bus.s_wready = (!busy || !rw) && ($urandom_range(0, 7) == 0);
                bus.s_rvalid = (!busy || rw) && ($urandom_range(0, 7) == 0);
            end
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = !rr_hold && ($urandom_range(0, 3) != 0);
        end
    end

    // cmd_ready must be high exactly when no transaction is outstanding
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                outstanding = 1'b0;
                continue;
            end
            chk("cmd_ready", bus.cmd_ready, !outstanding);
            if (bus.cmd_valid && bus.cmd_ready) outstanding = 1'b1;
            if (bus.rsp_valid && bus.rsp_ready) outstanding = 1'b0;
        end
    end

    initial begin
        op_t o;
        forever begin
            @(negedge clk);
            if (!reset_n || !(bus.m_wr_en || bus.m_rd_en)) continue;
            if (op_q.size() == 0) begin
                flag("unexpected_enable");
                continue;
            end
            o = op_q.pop_front();
            chk("enables", {bus.m_wr_en, bus.m_rd_en}, {o.write, !o.write});
            chk("enable_cycle", 64'(cyc), 64'(o.at));
            if (o.write) begin
                chk("m_waddr", bus.m_waddr, o.addr);
                chk("m_wdata", bus.m_wdata, o.data);
                chk("m_wstrobe", bus.m_wstrobe, o.strb);
            end else begin
                chk("m_raddr", bus.m_raddr, o.addr);
            end
        end
    end

    initial begin
        rsp_t cur;
        logic have_cur;
        int   exp_err;
        have_cur = 1'b0;
        exp_err = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                have_cur = 1'b0;
                exp_err = 0;
                continue;
            end
            if (!bus.rsp_valid) continue;
            if (!have_cur) begin
                if (rsp_q.size() == 0) begin
                    flag("unexpected_response");
                    continue;
                end
                cur = rsp_q.pop_front();
                have_cur = 1'b1;
                chk("rsp_latency", 64'(cyc), 64'(cur.at));
                if (cur.error && exp_err < 255) exp_err++;
                chk("err_cnt", err_cnt, 64'(exp_err));
            end
            chk("rsp_write", bus.rsp_write, cur.write);
            chk("rsp_rdata", bus.rsp_rdata, cur.rdata);
            chk("rsp_error", bus.rsp_error, cur.error);
            if (bus.rsp_ready) have_cur = 1'b0;
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_error"}, bus.rsp_error, 0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        chk({tag, "_m_wr_en"}, bus.m_wr_en, 0);
        chk({tag, "_m_rd_en"}, bus.m_rd_en, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        send(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1);
        send(1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h5, 1);
        send(1'b0, 32'h8, 32'h0, 4'h0, T + 5, 32'h0, 1);
        send(1'b1, 32'h6, 32'h1234, 4'h3, 0, 32'h0, 1);
        send(1'b0, 32'h10, 32'h0, 4'h0, T - 1, 32'hCAFE0001, 1);
        send(1'b1, 32'h14, 32'h77, 4'h1, T, 32'h0, 1);
        send(1'b0, 32'h3, 32'h0, 4'h0, 0, 32'h0, 1);
        drain();

        // Response stalled while the next command waits; long write ack runs into RESP/IDLE
        rr_hold = 1'b1;
        send(1'b1, 32'h20, 32'hA5A5A5A5, 4'hC, 0, 32'h0, 3);
        fork
            begin
                repeat (9) @(posedge clk);
                #1;
                rr_hold = 1'b0;
            end
        join_none
        send(1'b0, 32'h24, 32'h0, 4'h0, 1, 32'h0000ABCD, 1);
        send(1'b1, 32'h28, 32'h11223344, 4'hF, 2, 32'h0, 2);
        drain();

        // Reset in the middle of a read's wait: the command is dropped silently
        send(1'b0, 32'h30, 32'h0, 4'h0, T + 3, 32'h0, 1);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        rsp_q.delete();
        op_q.delete();
        cfg_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midwait_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2 * T + 5) @(posedge clk);
        #1;

        for (int i = 0; i < 300; i++) begin
            rand_cmd(1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Enough misaligned commands to drive err_cnt into saturation
        for (int i = 0; i < 270; i++)
            send(1'($urandom_range(0, 1)), {30'($urandom), 2'($urandom_range(1, 3))}, $urandom, 4'($urandom), 0, 32'h0, 1);
        drain();
        chk("ops_left", 64'(op_q.size()), 0);
        chk("err_cnt_saturated", err_cnt, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
